ysyx_040750_pipe_skid_reg: RTL and testbench
============================================

YSYX_040750_PIPE_SKID_REG -- requirements
Module: ysyx_040750_pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 64, payload width in bits (8..128).
REQ-002 Parameter DEPTH, default 2, storage entries (power of two, 1..8).
REQ-003 Parameter BUBBLE_DATA, default 64'h0000000000000013, payload substituted for converted entries; truncated or zero-extended to DATA_W.
REQ-004 I_sys_clk  input  1  single clock; all state updates on rising edge.
REQ-005 I_rst  input  1  reset, asynchronous, active-high.
REQ-006 I_in_valid  input  1  upstream offers I_data this cycle.
REQ-007 I_data  input  DATA_W  upstream payload.
REQ-008 O_allowin  output  1  block accepts I_data this cycle.
REQ-009 I_allowout  input  1  downstream accepts O_data this cycle.
REQ-010 I_stall  input  1  hold head entry; forces O_valid low.
REQ-011 I_flush  input  1  redirect or kill (jump, trap).
REQ-012 I_mark  input  1  convert the next accepted entry to a bubble, e.g. a pending interrupt.
REQ-013 O_valid  output  1  head entry is presented to downstream.
REQ-014 O_data  output  DATA_W  head payload.
REQ-015 O_bubble  output  1  head entry is a converted bubble.
REQ-016 O_count  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-017 Circular buffer with read and write pointers; no input-to-output bypass; an entry accepted at edge N is visible no earlier than after edge N.
REQ-018 pop = O_valid & I_allowout; O_valid = (count != 0) & ~I_stall; push = I_in_valid & O_allowin.
REQ-019 O_allowin = (count < DEPTH) | pop: simultaneous push and pop when full is legal, and count is unchanged.
REQ-020 Push only: count +1; pop only: count -1; pointers wrap modulo DEPTH.
REQ-021 O_data and O_bubble are driven from the head entry whenever count != 0, even if I_stall is high; when count = 0 they hold the last stored value and are ignored.
REQ-022 Pending-mark register: set at an edge where I_mark=1 and push=0; cleared at an edge where push=1; otherwise holds.
REQ-023 An entry pushed while I_mark=1 or pending-mark=1 is stored as BUBBLE_DATA with bubble flag 1; otherwise I_data is stored with bubble flag 0.
REQ-024 I_flush has priority over push: see REQ-030 for the resulting behaviour.
REQ-025 A pop in a flush cycle completes normally, because downstream has already sampled it.
REQ-026 DEPTH=1 degenerates to a single register; O_allowin = ~full | pop.

Reset
REQ-027 While I_rst=1: count=0, both pointers=0, pending-mark=0, all storage=0, and the storage bubble flags=0.
REQ-028 Resulting outputs: O_valid=0, O_count=0, O_data=0, O_bubble=0, O_allowin=1.
REQ-029 Reset asserted mid-transfer discards all entries immediately, with no edge required; the first push after deassertion lands at slot 0.

Configuration
REQ-030 Macro YSYX_040750_PIPE_BUBBLE_EN; behaviour with and without it:
  - Undefined: at a flush edge all entries not popped are discarded (count to 0, pointers to 0); a push in the same cycle is dropped.
  - Defined: at a flush edge entries are kept but rewritten to BUBBLE_DATA with bubble flag 1; a push in the same cycle is stored as a bubble; pointers and count follow REQ-020.

Verification
REQ-031 Reset then push 0xA, 0xB, 0xC with I_allowout=0, DEPTH=2: O_allowin drops after 2 pushes, O_count=2, 0xC is held off; then I_allowout=1: 0xC is accepted on the same edge as 0xA pops.
REQ-032 Empty buffer, push 0x55 at edge N: O_valid=1 with O_data=0x55 only after edge N; I_stall=1 keeps O_valid=0 and O_data=0x55 until the stall is released.
REQ-033 I_mark pulsed for one cycle while I_in_valid=0, then push 0x77: the stored entry is 0x13 with O_bubble=1; the next push 0x88 is delivered unmodified.
REQ-034 Buffer full (0x1, 0x2), I_flush=1 with pop and push 0x3 in the same cycle: 0x1 is consumed. Undefined macro: O_count=0 next cycle. Defined macro: entries 0x13 with O_bubble=1, O_count=2.
REQ-035 I_rst asserted asynchronously between edges with O_count=2: O_valid=0 and O_count=0 before the next edge; after release, a push lands and is read correctly, including pointer wrap after 2×DEPTH pushes.

Source files
------------

// File: rtl/ysyx_040750_pipe_skid_reg.sv
// rtl/ysyx_040750_pipe_skid_reg.sv - circular-buffer pipeline register with stall, flush and bubble marking
// Optional macro YSYX_040750_PIPE_BUBBLE_EN: flush rewrites held entries to bubbles instead of discarding them.
module ysyx_040750_pipe_skid_reg #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned DEPTH       = 2,
  parameter logic [63:0] BUBBLE_DATA = 64'h0000000000000013
) (
  input  logic                       I_sys_clk,
  input  logic                       I_rst,
  input  logic                       I_in_valid,
  input  logic [DATA_W-1:0]          I_data,
  output logic                       O_allowin,
  input  logic                       I_allowout,
  input  logic                       I_stall,
  input  logic                       I_flush,
  input  logic                       I_mark,
  output logic                       O_valid,
  output logic [DATA_W-1:0]          O_data,
  output logic                       O_bubble,
  output logic [$clog2(DEPTH+1)-1:0] O_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] BUBBLE_W = DATA_W'(BUBBLE_DATA);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  bub_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mark_q, mark_d;

  logic pop;
  logic push;
  logic to_bubble;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign O_valid   = (cnt_q != '0) & ~I_stall;
  assign pop       = O_valid & I_allowout;
  assign O_allowin = (cnt_q != CNT_FULL) | pop;
  assign push      = I_in_valid & O_allowin;
  assign to_bubble = I_mark | mark_q;
  assign O_count   = cnt_q;
  assign O_data    = mem_q[rd_ptr_q];
  assign O_bubble  = bub_q[rd_ptr_q];

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mark_d   = mark_q;
    if (push) begin
      mark_d = 1'b0;
    end else if (I_mark) begin
      mark_d = 1'b1;
    end
`ifdef YSYX_040750_PIPE_BUBBLE_EN
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
`else
    // Flush empties the buffer outright; the popped head was already taken downstream.
    if (I_flush) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
`endif
  end

  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mark_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mark_q   <= mark_d;
    end
  end

  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      bub_q <= '0;
    end else begin
`ifdef YSYX_040750_PIPE_BUBBLE_EN
      if (I_flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= BUBBLE_W;
        end
        bub_q <= '1;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= (I_flush | to_bubble) ? BUBBLE_W : I_data;
        bub_q[wr_ptr_q] <= I_flush | to_bubble;
      end
`else
      if (push & ~I_flush) begin
        mem_q[wr_ptr_q] <= to_bubble ? BUBBLE_W : I_data;
        bub_q[wr_ptr_q] <= to_bubble;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_040750_pipe_skid_reg.sv
// tb/tb_ysyx_040750_pipe_skid_reg.sv - scoreboard bench for ysyx_040750_pipe_skid_reg
module tb_ysyx_040750_pipe_skid_reg;

  localparam int DEPTH = 2;
  localparam logic [63:0] BUB = 64'h13;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, allowout, stall, flush, mark;
  logic [63:0] data;
  logic        allowin, valid, bubble;
  logic [63:0] odata;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  logic [63:0] qd[$];
  bit          qb[$];
  bit          pend = 1'b0;
  bit          m_valid, m_allow, m_pop, m_push;
  int          m_cnt;

  always #5 clk = ~clk;

  ysyx_040750_pipe_skid_reg dut (
    .I_sys_clk (clk),
    .I_rst     (rst),
    .I_in_valid(in_valid),
    .I_data    (data),
    .O_allowin (allowin),
    .I_allowout(allowout),
    .I_stall   (stall),
    .I_flush   (flush),
    .I_mark    (mark),
    .O_valid   (valid),
    .O_data    (odata),
    .O_bubble  (bubble),
    .O_count   (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: predicts handshakes from its own occupancy and tracks expected entries.
  always @(negedge clk) begin
    if (rst) begin
      qd.delete();
      qb.delete();
      pend = 1'b0;
    end else begin
      m_cnt   = qd.size();
      m_valid = (m_cnt != 0) && !stall;
      m_allow = (m_cnt < DEPTH) || (m_valid && allowout);
      m_pop   = m_valid && allowout;
      m_push  = in_valid && m_allow;
      chk("mon_count", 64'(count), 64'(m_cnt));
      chk("mon_valid", 64'(valid), 64'(m_valid));
      chk("mon_allowin", 64'(allowin), 64'(m_allow));
      if (m_cnt != 0) begin
        chk("mon_data", odata, qd[0]);
        chk("mon_bubble", 64'(bubble), 64'(qb[0]));
      end
      if (m_pop) begin
        void'(qd.pop_front());
        void'(qb.pop_front());
      end
      if (flush) begin
`ifdef YSYX_040750_PIPE_BUBBLE_EN
        for (int i = 0; i < qd.size(); i++) begin
          qd[i] = BUB;
          qb[i] = 1'b1;
        end
        if (m_push) begin
          qd.push_back(BUB);
          qb.push_back(1'b1);
        end
`else
        qd.delete();
        qb.delete();
`endif
      end else if (m_push) begin
        qd.push_back((mark || pend) ? BUB : data);
        qb.push_back(mark || pend);
      end
      if (m_push) pend = 1'b0;
      else if (mark) pend = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; allowout = 1'b0; stall = 1'b0;
    flush = 1'b0; mark = 1'b0; data = '0;
    cyc(); cyc();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_data", odata, 64'd0);
    chk("rst_bubble", 64'(bubble), 64'd0);
    chk("rst_allowin", 64'(allowin), 64'd1);
    rst = 1'b0;
    cyc();

    // Fill to capacity with downstream blocked, then pop and push on one edge.
    in_valid = 1'b1; data = 64'hA; cyc();
    data = 64'hB; cyc();
    data = 64'hC;
    chk("full_allowin", 64'(allowin), 64'd0);
    chk("full_count", 64'(count), 64'd2);
    cyc();
    chk("held_count", 64'(count), 64'd2);
    allowout = 1'b1; cyc();
    chk("swap_count", 64'(count), 64'd2);
    chk("swap_head", odata, 64'hB);
    in_valid = 1'b0; cyc(); cyc();
    chk("drain_count", 64'(count), 64'd0);

    // No bypass, and stall masks valid while the head payload stays visible.
    in_valid = 1'b1; data = 64'h55;
    chk("nobypass_valid", 64'(valid), 64'd0);
    cyc();
    in_valid = 1'b0;
    chk("after_push_valid", 64'(valid), 64'd1);
    chk("after_push_data", odata, 64'h55);
    stall = 1'b1; #1;
    chk("stall_valid", 64'(valid), 64'd0);
    chk("stall_data", odata, 64'h55);
    cyc(); cyc();
    chk("stall_count", 64'(count), 64'd1);
    stall = 1'b0; cyc(); cyc();

    // A lone mark pulse converts the next accepted entry only.
    allowout = 1'b0; mark = 1'b1; cyc();
    mark = 1'b0; in_valid = 1'b1; data = 64'h77; cyc();
    data = 64'h88; cyc();
    in_valid = 1'b0;
    chk("mark_data", odata, 64'h13);
    chk("mark_bubble", 64'(bubble), 64'd1);
    allowout = 1'b1; cyc();
    chk("after_mark_data", odata, 64'h88);
    chk("after_mark_bubble", 64'(bubble), 64'd0);
    cyc(); cyc();

    // Flush on a full buffer with a pop and a push in the same cycle.
    allowout = 1'b0; in_valid = 1'b1; data = 64'h1; cyc();
    data = 64'h2; cyc();
    data = 64'h3; allowout = 1'b1; flush = 1'b1; cyc();
    flush = 1'b0; in_valid = 1'b0; allowout = 1'b0;
`ifdef YSYX_040750_PIPE_BUBBLE_EN
    chk("flush_count", 64'(count), 64'd2);
    chk("flush_data", odata, 64'h13);
    chk("flush_bubble", 64'(bubble), 64'd1);
`else
    chk("flush_count", 64'(count), 64'd0);
`endif
    allowout = 1'b1; cyc(); cyc(); cyc();

    // Asynchronous reset between edges, then a stream long enough to wrap the pointers.
    allowout = 1'b0; in_valid = 1'b1; data = 64'h21; cyc();
    data = 64'h22; cyc();
    in_valid = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd2);
    #2 rst = 1'b1; #1;
    chk("async_rst_valid", 64'(valid), 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    in_valid = 1'b1; allowout = 1'b1; data = 64'h30;
    cyc();
    chk("post_rst_first", odata, 64'h30);
    for (int k = 1; k < 7; k++) begin
      data = 64'h30 + 64'(k);
      allowout = (k != 3);
      cyc();
    end
    in_valid = 1'b0; allowout = 1'b1;
    cyc(); cyc(); cyc();
    chk("final_count", 64'(count), 64'd0);
    chk("final_model_empty", 64'(qd.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
